branch_resolve_unit: RTL and testbench



---
 rtl/branch_resolve_unit_if.sv | 28 ++
 rtl/branch_resolve_unit.sv | 148 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the ID/EX boundary and the branch resolve unit.
// master = upstream pipeline (drives requests, sees results), slave = the unit.
interface branch_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              valid_i;
    logic              Branch_i;
    logic [2:0]        cond_i;
    logic              Signed_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [PC_W-1:0]   pc_i;
    logic              pred_taken_i;
    logic              valid_o;
    logic              Branch_o;
    logic              mispredict_o;

    modport master (
        output valid_i, Branch_i, cond_i, Signed_i, RSdata_i, RTdata_i, pc_i, pred_taken_i,
        input  valid_o, Branch_o, mispredict_o
    );

    modport slave (
        input  valid_i, Branch_i, cond_i, Signed_i, RSdata_i, RTdata_i, pc_i, pred_taken_i,
        output valid_o, Branch_o, mispredict_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: one registered stage evaluating conditional branches,
// plus a 2-bit saturating-counter BHT trained when a result is consumed.
// Optional statistics counters are built only when BRU_STATS_EN is defined;
// otherwise stat_branches_o / stat_mispred_o read 0.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PC_W-1:0]      lookup_pc_i,
    output logic                 lookup_taken_o,
    input  logic                 stall_i,
    input  logic                 flush_i,
    branch_resolve_unit_if.slave bus,
    output logic [31:0]          stat_branches_o,
    output logic [31:0]          stat_mispred_o
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic                            vld_q, vld_d;
    logic                            taken_q, taken_d;
    logic                            pred_q, pred_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [BHT_DEPTH-1:0][1:0]       bht_q, bht_d;

    logic accept;
    logic outcome;
    logic consume;
    logic eq, gt, lt;

    // PC bits outside the index field do not take part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[1:0], lookup_pc_i[PC_W-1:IDX_W+2],
                              bus.pc_i[1:0], bus.pc_i[PC_W-1:IDX_W+2]};

    assign accept  = bus.valid_i & bus.Branch_i;
    // A flushed result is discarded, so it neither trains nor counts.
    assign consume = vld_q & ~stall_i & ~flush_i;

    // Condition evaluation on the raw operands in the accept cycle.
    always_comb begin
        eq = (bus.RSdata_i == bus.RTdata_i);
        if (bus.Signed_i) begin
            gt = $signed(bus.RSdata_i) > $signed(bus.RTdata_i);
            lt = $signed(bus.RSdata_i) < $signed(bus.RTdata_i);
        end else begin
            gt = bus.RSdata_i > bus.RTdata_i;
            lt = bus.RSdata_i < bus.RTdata_i;
        end
        case (bus.cond_i)
            3'b000:  outcome = ~eq;
            3'b001:  outcome = eq;
            3'b010:  outcome = gt;
            3'b011:  outcome = ~lt;
            3'b100:  outcome = lt;
            3'b101:  outcome = ~gt;
            3'b110:  outcome = 1'b1;
            default: outcome = 1'b0;
        endcase
    end

    // Stage register next state: flush beats stall beats normal flow.
    always_comb begin
        vld_d   = vld_q;
        taken_d = taken_q;
        pred_d  = pred_q;
        idx_d   = idx_q;
        if (flush_i) begin
            vld_d   = 1'b0;
            taken_d = 1'b0;
            pred_d  = 1'b0;
            idx_d   = '0;
        end else if (!stall_i) begin
            vld_d   = accept;
            taken_d = accept & outcome;
            pred_d  = accept & bus.pred_taken_i;
            idx_d   = accept ? bus.pc_i[IDX_W+1:2] : '0;
        end
    end

    // BHT training: saturating up on taken, down on not-taken, once per consumed result.
    always_comb begin
        bht_d = bht_q;
        if (consume) begin
            if (taken_q && bht_q[idx_q] != 2'b11)
                bht_d[idx_q] = bht_q[idx_q] + 2'b01;
            else if (!taken_q && bht_q[idx_q] != 2'b00)
                bht_d[idx_q] = bht_q[idx_q] - 2'b01;
        end
    end

    // State registers with synchronous reset; BHT entries reset to weak not-taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
            pred_q  <= 1'b0;
            idx_q   <= '0;
            bht_q   <= {BHT_DEPTH{2'b01}};
        end else begin
            vld_q   <= vld_d;
            taken_q <= taken_d;
            pred_q  <= pred_d;
            idx_q   <= idx_d;
            bht_q   <= bht_d;
        end
    end

    assign bus.valid_o      = vld_q;
    assign bus.Branch_o     = taken_q;
    assign bus.mispredict_o = vld_q & (taken_q != pred_q);
    // No bypass: a same-cycle update is visible only from the next cycle.
    assign lookup_taken_o   = bht_q[lookup_pc_i[IDX_W+1:2]][1];

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Saturating statistics counters over consumed results.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (consume) begin
            if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
            if (bus.mispredict_o && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`else
    assign stat_branches_o = 32'd0;
    assign stat_mispred_o  = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: condition table, BHT training and
// saturation, stall/flush corner cases, statistics counters.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic        stall, flush;
    logic [31:0] stat_br, stat_mp;

    int errors = 0;
    int checks = 0;

    branch_resolve_unit_if #(.DATA_W(32), .PC_W(32)) bus ();

    branch_resolve_unit #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc), .lookup_taken_o(lookup_taken),
        .stall_i(stall), .flush_i(flush), .bus(bus),
        .stat_branches_o(stat_br), .stat_mispred_o(stat_mp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cond;
        logic        sgn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        pred;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i = 1'b0; bus.Branch_i = 1'b0; bus.cond_i = 3'b111; bus.Signed_i = 1'b0;
        bus.RSdata_i = '0; bus.RTdata_i = '0; bus.pc_i = '0; bus.pred_taken_i = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic p);
        bus.valid_i = 1'b1; bus.Branch_i = 1'b1; bus.cond_i = c; bus.Signed_i = s;
        bus.RSdata_i = a; bus.RTdata_i = b; bus.pc_i = pc; bus.pred_taken_i = p;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; idle();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic stats_seq();
        // five consumed branches, two mispredicted (#2, #4), sixth flushed
        issue(3'b110, 0, 0, 0, 32'h100, 1); tick();
        issue(3'b110, 0, 0, 0, 32'h104, 0); tick();
        issue(3'b111, 0, 0, 0, 32'h108, 0); tick();
        issue(3'b111, 0, 0, 0, 32'h10C, 1); tick();
        issue(3'b001, 0, 3, 3, 32'h110, 1); tick();
        issue(3'b110, 0, 0, 0, 32'h114, 0); tick();
        idle(); flush = 1'b1; tick();
        flush = 1'b0; tick();
    endtask

    initial begin
        vecs[0]  = '{3'b010, 0, 32'hFFFF_FFFF, 32'd1, 0, 1};
        vecs[1]  = '{3'b010, 1, 32'hFFFF_FFFF, 32'd1, 1, 0};
        vecs[2]  = '{3'b101, 1, 32'hFFFF_FFFF, 32'd1, 0, 1};
        vecs[3]  = '{3'b001, 0, 32'hFFFF_FFFF, 32'd1, 0, 0};
        vecs[4]  = '{3'b000, 0, 32'hFFFF_FFFF, 32'd1, 1, 1};
        vecs[5]  = '{3'b110, 0, 32'hFFFF_FFFF, 32'd1, 0, 1};
        vecs[6]  = '{3'b111, 0, 32'hFFFF_FFFF, 32'd1, 1, 0};
        vecs[7]  = '{3'b011, 1, 32'd5,         32'd5, 1, 1};
        vecs[8]  = '{3'b100, 0, 32'd1, 32'hFFFF_FFFF, 0, 1};
        vecs[9]  = '{3'b100, 1, 32'd1, 32'hFFFF_FFFF, 0, 0};
        vecs[10] = '{3'b101, 0, 32'hFFFF_FFFF, 32'd1, 1, 0};
        vecs[11] = '{3'b011, 0, 32'd0,         32'd1, 0, 0};
        vecs[12] = '{3'b111, 1, 32'd7,         32'd7, 0, 0};
        vecs[13] = '{3'b001, 1, 32'd7,         32'd7, 0, 1};

        lookup_pc = 32'h0;
        // reset: garbage on the request bus while reset is held
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        issue(3'b110, 0, 0, 0, 32'h40, 0);
        tick(); tick();
        rst = 1'b0; idle();
        check("rst valid_o", bus.valid_o, 0);
        check("rst Branch_o", bus.Branch_o, 0);
        check("rst mispredict_o", bus.mispredict_o, 0);
        check("rst stat_br", stat_br, 0);
        check("rst stat_mp", stat_mp, 0);
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            check("rst lookup", lookup_taken, 0);
        end

        // condition table, back-to-back
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].cond, vecs[i].sgn, vecs[i].rs, vecs[i].rt, 32'(i) << 2, vecs[i].pred);
            tick();
            check($sformatf("vec%0d valid", i), bus.valid_o, 1);
            check($sformatf("vec%0d taken", i), bus.Branch_o, vecs[i].exp_taken);
            check($sformatf("vec%0d mispred", i), bus.mispredict_o, vecs[i].exp_taken != vecs[i].pred);
        end
        idle(); tick();
        check("single-cycle valid", bus.valid_o, 0);
        // non-branch request is not accepted
        issue(3'b110, 0, 0, 0, 32'h0, 0); bus.Branch_i = 1'b0; tick();
        check("non-branch valid", bus.valid_o, 0);

        // training at PC 0x40 (index 0)
        do_reset();
        lookup_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            issue(3'b001, 0, 5, 5, 32'h40, 0); tick();
            check("train mispred", bus.mispredict_o, 1);
            check("train lookup", lookup_taken, i == 0 ? 0 : 1);
        end
        idle(); tick();
        check("train lookup sat", lookup_taken, 1);
        for (int i = 0; i < 4; i++) begin
            issue(3'b001, 0, 1, 2, 32'h40, 1); tick();
            check("dec taken", bus.Branch_o, 0);
            if (i > 0) check("dec lookup", lookup_taken, i == 1 ? 1 : 0);
        end
        idle(); tick();
        check("dec lookup 4th", lookup_taken, 0);
        issue(3'b110, 0, 0, 0, 32'h40, 0); tick(); idle(); tick();
        check("from 00 lookup", lookup_taken, 0);
        issue(3'b110, 0, 0, 0, 32'h40, 0); tick(); idle(); tick();
        check("from 01 lookup", lookup_taken, 1);

        // stall: pending taken result at index 1 held for 3 cycles
        do_reset();
        lookup_pc = 32'h44;
        issue(3'b110, 0, 0, 0, 32'h44, 0); tick();
        stall = 1'b1;
        issue(3'b111, 0, 0, 0, 32'h44, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall valid", bus.valid_o, 1);
            check("stall taken", bus.Branch_o, 1);
            check("stall mispred", bus.mispredict_o, 1);
            check("stall lookup", lookup_taken, 0);
        end
        stall = 1'b0; idle(); tick();
        check("stall release valid", bus.valid_o, 0);
        check("stall single update", lookup_taken, 1);
        issue(3'b111, 0, 0, 0, 32'h44, 0); tick(); idle(); tick();
        check("stall no double update", lookup_taken, 0);

        // flush: pending result and new request both discarded
        do_reset();
        lookup_pc = 32'h48;
        issue(3'b110, 0, 0, 0, 32'h48, 0); tick();
        flush = 1'b1; issue(3'b110, 0, 0, 0, 32'h48, 0); tick();
        flush = 1'b0; idle();
        check("flush valid", bus.valid_o, 0);
        check("flush Branch_o", bus.Branch_o, 0);
        tick();
        check("flush valid after", bus.valid_o, 0);
        check("flush bht unchanged", lookup_taken, 0);

        // statistics
        do_reset();
        stats_seq();
`ifdef BRU_STATS_EN
        check("stat_branches", stat_br, 5);
        check("stat_mispred", stat_mp, 2);
`else
        check("stat_branches off", stat_br, 0);
        check("stat_mispred off", stat_mp, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
